// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table and lookup function, key-schedule
// round constants, AES-128 sizing localparams and the key-expansion state enum.
// Ports: none (package).
package aes_pkg;

  localparam int NR              = 10;
  localparam int KEY_BITS        = 128;
  localparam int ROUND_KEYS_BITS = KEY_BITS * (NR + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ks_state_e;

  // Rcon[1..10] stored at index 0..9.
  localparam logic [7:0] RCON [0:NR-1] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: one byte in, its substituted byte out.
// Ports: plain [7:0] byte to substitute; subst [7:0] S-box(plain).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  assign subst = sbox(plain);

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock, 11 round keys held
// on out until reset. Ports: clk, rst (sync, active-high), key [127:0],
// start (sampled in IDLE), out [1407:0] (round key 0 in the MSBs), finish.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEY_BITS-1:0]        key,
  input  logic                       start,
  output logic [ROUND_KEYS_BITS-1:0] out,
  output logic                       finish
);

  ks_state_e state, state_next;
  logic [3:0] rc;

  // Index 0 is the most significant slot, so the packed array maps straight
  // onto out with round key 0 in out[1407:1280].
  logic [0:NR][KEY_BITS-1:0] rk_q;

  logic [KEY_BITS-1:0] prev_rk, next_rk;
  logic [31:0] wp0, wp1, wp2, wp3;
  logic [31:0] rot, sub, temp;
  logic [31:0] w4, w5, w6, w7;

  assign out = rk_q;

  // ---------------- datapath: one full round key per cycle ----------------
  assign prev_rk = rk_q[rc - 4'd1];
  assign wp0     = prev_rk[127:96];
  assign wp1     = prev_rk[95:64];
  assign wp2     = prev_rk[63:32];
  assign wp3     = prev_rk[31:0];

  // RotWord: leftmost byte moves to the right end.
  assign rot = {wp3[23:0], wp3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .plain (rot[8*g +: 8]),
      .subst (sub[8*g +: 8])
    );
  end

  assign temp    = sub ^ {RCON[rc - 4'd1], 24'h0};
  assign w4      = wp0 ^ temp;
  assign w5      = wp1 ^ w4;
  assign w6      = wp2 ^ w5;
  assign w7      = wp3 ^ w6;
  assign next_rk = {w4, w5, w6, w7};

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      finish <= 1'b0;
    end else begin
      state  <= state_next;
      finish <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (rc == 4'(NR)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- round-key storage and round counter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q <= '0;
      rc   <= 4'd1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rk_q    <= '0;
            rk_q[0] <= key;
            rc      <= 4'd1;
          end
        end
        BUSY: begin
          rk_q[rc] <= next_rk;
          if (rc != 4'(NR)) rc <= rc + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
module tb_aes_key_expansion;

  localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic          clk;
  logic          rst;
  logic [127:0]  key;
  logic          start;
  logic [1407:0] out;
  logic          finish;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb_ref [256];

  aes_key_expansion dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .start  (start),
    .out    (out),
    .finish (finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (GF(2^8) arithmetic, FIPS word loop) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x} >> (8 - n);
    return d[7:0];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);  // a^254 = a^-1, 0 -> 0
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand_ref(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon = 8'h01;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] rk_of(input logic [1407:0] v, input int i);
    return v[1407-128*i -: 128];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: quiet; 1: key forced to all-ones and start dropped 2 cycles after
  // the start edge; 2: key and start randomly churned throughout BUSY.
  task automatic run_expand(input string tag, input logic [127:0] k, input int mode);
    logic [1407:0] exp;
    exp   = expand_ref(k);
    key   = k;
    start = 1'b1;
    tick();
    check($sformatf("%s_rk0", tag), rk_of(out, 0), k);
    check($sformatf("%s_fin0", tag), {127'b0, finish}, 128'd0);
    for (int i = 1; i <= 10; i++) begin
      if (mode == 1 && i == 3) begin
        key   = '1;
        start = 1'b0;
      end else if (mode == 2) begin
        key   = rand128();
        start = 1'($urandom_range(0, 1));
      end
      tick();
      check($sformatf("%s_rk%0d", tag, i), rk_of(out, i), rk_of(exp, i));
      check($sformatf("%s_fin%0d", tag, i), {127'b0, finish}, {127'b0, (i == 10)});
    end
    for (int i = 0; i <= 10; i++)
      check($sformatf("%s_final_rk%0d", tag, i), rk_of(out, i), rk_of(exp, i));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [1407:0] saved;

    for (int i = 0; i < 256; i++) sb_ref[i] = sbox_calc(8'(i));

    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_out", {127'b0, |out}, 128'd0);
    check("reset_fin", {127'b0, finish}, 128'd0);

    // Idle hold: start low, key wandering.
    for (int c = 0; c < 20; c++) begin
      key = rand128();
      tick();
      check("idle_out", {127'b0, |out}, 128'd0);
      check("idle_fin", {127'b0, finish}, 128'd0);
    end

    // FIPS-197 A.1 vector.
    run_expand("a1", A1_KEY, 0);
    check("a1_known_rk0", rk_of(out, 0), A1_KEY);
    check("a1_known_rk1", rk_of(out, 1), A1_RK1);
    check("a1_known_rk10", out[127:0], A1_RK10);

    // DONE is sticky against start and a new key.
    saved = out;
    start = 1'b1;
    key   = '0;
    for (int c = 0; c < 15; c++) begin
      tick();
      for (int i = 0; i <= 10; i++) check("sticky_rk", rk_of(out, i), rk_of(saved, i));
      check("sticky_fin", {127'b0, finish}, 128'd1);
    end

    // Reset five edges into an A.1 expansion.
    start = 1'b0;
    do_reset();
    key   = A1_KEY;
    start = 1'b1;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_out", {127'b0, |out}, 128'd0);
    check("midrst_fin", {127'b0, finish}, 128'd0);
    rst = 1'b0;
    run_expand("zero", 128'd0, 0);
    check("zero_known_rk1", rk_of(out, 1), Z_RK1);
    check("zero_known_rk10", out[127:0], Z_RK10);

    // Key switched to all-ones (and start dropped) during BUSY.
    start = 1'b0;
    do_reset();
    run_expand("keychg", A1_KEY, 1);
    check("keychg_known_rk1", rk_of(out, 1), A1_RK1);
    check("keychg_known_rk10", out[127:0], A1_RK10);

    // Random keys with input churn during BUSY.
    for (int n = 0; n < 8; n++) begin
      start = 1'b0;
      do_reset();
      run_expand($sformatf("rnd%0d", n), rand128(), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
